// File: rtl/npu_axil_arbiter_if.sv
// Bus bundle for the N-to-1 AXI4-lite arbiter.
// Carries the LSU-side channel vectors and the single external master port.
interface npu_axil_arbiter_if #(
  parameter int N_CH = 3,
  parameter int A_W  = 32,
  parameter int D_W  = 32,
  parameter int S_W  = D_W / 8
);
  logic [N_CH-1:0]          lsu_wa_valid, lsu_wa_ready;
  logic [N_CH-1:0][A_W-1:0] lsu_wa_addr;
  logic [N_CH-1:0]          lsu_wd_valid, lsu_wd_ready;
  logic [N_CH-1:0][D_W-1:0] lsu_wd_data;
  logic [N_CH-1:0][S_W-1:0] lsu_wd_strb;
  logic [N_CH-1:0]          lsu_wr_valid, lsu_wr_ready;
  logic [N_CH-1:0]          lsu_ra_valid, lsu_ra_ready;
  logic [N_CH-1:0][A_W-1:0] lsu_ra_addr;
  logic [N_CH-1:0]          lsu_rd_valid, lsu_rd_ready;
  logic [N_CH-1:0][D_W-1:0] lsu_rd_data;

  logic           ext_wa_valid, ext_wa_ready;
  logic [A_W-1:0] ext_wa_addr;
  logic           ext_wd_valid, ext_wd_ready;
  logic [D_W-1:0] ext_wd_data;
  logic [S_W-1:0] ext_wd_strb;
  logic           ext_wr_valid, ext_wr_ready;
  logic           ext_ra_valid, ext_ra_ready;
  logic [A_W-1:0] ext_ra_addr;
  logic           ext_rd_valid, ext_rd_ready;
  logic [D_W-1:0] ext_rd_data;

  // The arbiter itself.
  modport slave (
    input  lsu_wa_valid, lsu_wa_addr, lsu_wd_valid, lsu_wd_data, lsu_wd_strb, lsu_wr_ready,
    input  lsu_ra_valid, lsu_ra_addr, lsu_rd_ready,
    output lsu_wa_ready, lsu_wd_ready, lsu_wr_valid, lsu_ra_ready, lsu_rd_valid, lsu_rd_data,
    input  ext_wa_ready, ext_wd_ready, ext_wr_valid, ext_ra_ready, ext_rd_valid, ext_rd_data,
    output ext_wa_valid, ext_wa_addr, ext_wd_valid, ext_wd_data, ext_wd_strb, ext_wr_ready,
    output ext_ra_valid, ext_ra_addr, ext_rd_ready
  );

  // The environment: LSU channels plus external memory.
  modport master (
    output lsu_wa_valid, lsu_wa_addr, lsu_wd_valid, lsu_wd_data, lsu_wd_strb, lsu_wr_ready,
    output lsu_ra_valid, lsu_ra_addr, lsu_rd_ready,
    input  lsu_wa_ready, lsu_wd_ready, lsu_wr_valid, lsu_ra_ready, lsu_rd_valid, lsu_rd_data,
    output ext_wa_ready, ext_wd_ready, ext_wr_valid, ext_ra_ready, ext_rd_valid, ext_rd_data,
    input  ext_wa_valid, ext_wa_addr, ext_wd_valid, ext_wd_data, ext_wd_strb, ext_wr_ready,
    input  ext_ra_valid, ext_ra_addr, ext_rd_ready
  );
endinterface

// File: rtl/npu_axil_arbiter.sv
// N-to-1 AXI4-lite interconnect: round-robin request arbitration per direction with
// registered request slots, in-order response routing through per-direction ID FIFOs.
module npu_axil_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] cnt_reg;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_reg == '0);
  assign full  = (cnt_reg == CW'(DEPTH));
  assign head  = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_id;
        wr_ptr_reg          <= inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end
endmodule

module npu_axil_arbiter #(
  parameter int N_CH      = 3,
  parameter int A_W       = 32,
  parameter int D_W       = 32,
  parameter int S_W       = D_W / 8,
  parameter int MAX_OUTST = 4
) (
  input logic              clk_i,
  input logic              arstn_i,
  npu_axil_arbiter_if.slave bus
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Returns {found, index}; search starts at ptr, which holds the channel after the last grant.
  function automatic logic [IW:0] rr_pick(input logic [N_CH-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N_CH);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic           ra_valid_reg;
  logic [A_W-1:0] ra_addr_reg;
  logic [IW-1:0]  ra_ptr_reg, ra_ptr_next;
  logic [IW:0]    ra_pick;
  logic           ra_grant, rid_empty, rid_full, rid_pop;
  logic [IW-1:0]  rid_head;
  logic [N_CH-1:0] rd_sel;

  logic           wa_valid_reg, wd_valid_reg;
  logic [A_W-1:0] wa_addr_reg;
  logic [D_W-1:0] wd_data_reg;
  logic [S_W-1:0] wd_strb_reg;
  logic [IW-1:0]  w_ptr_reg, w_ptr_next;
  logic [IW:0]    w_pick;
  logic           w_grant, wid_empty, wid_full, wid_pop;
  logic [IW-1:0]  wid_head;
  logic [N_CH-1:0] wr_sel;

  // Grants are gated by reset so request readies stay low while reset is held.
  assign ra_pick     = rr_pick(bus.lsu_ra_valid, ra_ptr_reg);
  assign ra_grant    = arstn_i & ra_pick[IW] & ~rid_full & (~ra_valid_reg | bus.ext_ra_ready);
  assign ra_ptr_next = (ra_pick[IW-1:0] == IW'(N_CH - 1)) ? '0 : ra_pick[IW-1:0] + 1'b1;
  assign bus.lsu_ra_ready = N_CH'(ra_grant) << ra_pick[IW-1:0];

  assign w_pick     = rr_pick(bus.lsu_wa_valid & bus.lsu_wd_valid, w_ptr_reg);
  assign w_grant    = arstn_i & w_pick[IW] & ~wid_full
                    & (~wa_valid_reg | bus.ext_wa_ready) & (~wd_valid_reg | bus.ext_wd_ready);
  assign w_ptr_next = (w_pick[IW-1:0] == IW'(N_CH - 1)) ? '0 : w_pick[IW-1:0] + 1'b1;
  assign bus.lsu_wa_ready = N_CH'(w_grant) << w_pick[IW-1:0];
  assign bus.lsu_wd_ready = N_CH'(w_grant) << w_pick[IW-1:0];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ra_valid_reg <= 1'b0;
      ra_addr_reg  <= '0;
      ra_ptr_reg   <= '0;
    end else if (ra_grant) begin
      ra_valid_reg <= 1'b1;
      ra_addr_reg  <= bus.lsu_ra_addr[ra_pick[IW-1:0]];
      ra_ptr_reg   <= ra_ptr_next;
    end else if (bus.ext_ra_ready) begin
      ra_valid_reg <= 1'b0;
    end
  end

  // WA and WD are loaded together but drain independently.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wa_valid_reg <= 1'b0;
      wd_valid_reg <= 1'b0;
      wa_addr_reg  <= '0;
      wd_data_reg  <= '0;
      wd_strb_reg  <= '0;
      w_ptr_reg    <= '0;
    end else if (w_grant) begin
      wa_valid_reg <= 1'b1;
      wd_valid_reg <= 1'b1;
      wa_addr_reg  <= bus.lsu_wa_addr[w_pick[IW-1:0]];
      wd_data_reg  <= bus.lsu_wd_data[w_pick[IW-1:0]];
      wd_strb_reg  <= bus.lsu_wd_strb[w_pick[IW-1:0]];
      w_ptr_reg    <= w_ptr_next;
    end else begin
      if (bus.ext_wa_ready) wa_valid_reg <= 1'b0;
      if (bus.ext_wd_ready) wd_valid_reg <= 1'b0;
    end
  end

  assign bus.ext_ra_valid = ra_valid_reg;
  assign bus.ext_ra_addr  = ra_addr_reg;
  assign bus.ext_wa_valid = wa_valid_reg;
  assign bus.ext_wa_addr  = wa_addr_reg;
  assign bus.ext_wd_valid = wd_valid_reg;
  assign bus.ext_wd_data  = wd_data_reg;
  assign bus.ext_wd_strb  = wd_strb_reg;

  npu_axil_id_fifo #(.DEPTH(MAX_OUTST), .W(IW)) u_rid (
    .clk_i(clk_i), .arstn_i(arstn_i), .push(ra_grant), .push_id(ra_pick[IW-1:0]),
    .pop(rid_pop), .head(rid_head), .empty(rid_empty), .full(rid_full)
  );

  npu_axil_id_fifo #(.DEPTH(MAX_OUTST), .W(IW)) u_wid (
    .clk_i(clk_i), .arstn_i(arstn_i), .push(w_grant), .push_id(w_pick[IW-1:0]),
    .pop(wid_pop), .head(wid_head), .empty(wid_empty), .full(wid_full)
  );

  // An empty FIFO selects no channel, so stray external responses are never acked.
  assign rd_sel           = rid_empty ? '0 : (N_CH'(1) << rid_head);
  assign bus.lsu_rd_valid = bus.ext_rd_valid ? rd_sel : '0;
  assign bus.ext_rd_ready = |(rd_sel & bus.lsu_rd_ready);
  assign rid_pop          = bus.ext_rd_valid & bus.ext_rd_ready;

  assign wr_sel           = wid_empty ? '0 : (N_CH'(1) << wid_head);
  assign bus.lsu_wr_valid = bus.ext_wr_valid ? wr_sel : '0;
  assign bus.ext_wr_ready = |(wr_sel & bus.lsu_wr_ready);
  assign wid_pop          = bus.ext_wr_valid & bus.ext_wr_ready;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rd_bcast
      assign bus.lsu_rd_data[gi] = bus.ext_rd_data;
    end
  endgenerate
endmodule

// File: tb/tb_npu_axil_arbiter.sv
// Self-checking bench for npu_axil_arbiter: directed scenarios then random traffic,
// every cycle compared against a queue-based transaction model.
module tb_npu_axil_arbiter;
  localparam int N = 3, AW = 32, DW = 32, SW = 4, MO = 4;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  npu_axil_arbiter_if #(.N_CH(N), .A_W(AW), .D_W(DW), .S_W(SW)) bus ();
  npu_axil_arbiter #(.N_CH(N), .A_W(AW), .D_W(DW), .S_W(SW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .arstn_i(arstn), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;

  // Model: request slots as plain values, outstanding IDs as queues, last grant per direction.
  logic          m_ra_v, m_wa_v, m_wd_v;
  logic [AW-1:0] m_ra_a, m_wa_a;
  logic [DW-1:0] m_wd_d;
  logic [SW-1:0] m_wd_s;
  int            m_rq[$], m_wq[$];
  int            m_rlast, m_wlast;
  logic [N-1:0]  m_ra_g, m_w_g;
  int            ra_order[$];
  int            w_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ra_v = 0; m_wa_v = 0; m_wd_v = 0;
    m_ra_a = '0; m_wa_a = '0; m_wd_d = '0; m_wd_s = '0;
    m_rq.delete(); m_wq.delete();
    m_rlast = N - 1; m_wlast = N - 1;
    m_ra_g = '0; m_w_g = '0;
  endtask

  function automatic int rr(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] order_code();
    logic [63:0] c = '0;
    foreach (ra_order[i]) c = (c << 4) | 64'(ra_order[i] + 1);
    return c;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_ra_ready"}, bus.lsu_ra_ready, 0);
    chk({tag, "_wa_ready"}, bus.lsu_wa_ready, 0);
    chk({tag, "_wd_ready"}, bus.lsu_wd_ready, 0);
    chk({tag, "_rd_valid"}, bus.lsu_rd_valid, 0);
    chk({tag, "_wr_valid"}, bus.lsu_wr_valid, 0);
    chk({tag, "_ext_ra"}, {bus.ext_ra_valid, bus.ext_ra_addr}, 0);
    chk({tag, "_ext_wa"}, {bus.ext_wa_valid, bus.ext_wa_addr}, 0);
    chk({tag, "_ext_wd"}, {bus.ext_wd_valid, bus.ext_wd_strb, bus.ext_wd_data}, 0);
    chk({tag, "_ext_resp_rdy"}, {bus.ext_rd_ready, bus.ext_wr_ready}, 0);
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic cycle();
    int g, gw, h;
    logic [N-1:0] e;
    logic rrdy, wrdy, rpop, wpop;
    @(negedge clk);
    g = -1;
    if ((!m_ra_v || bus.ext_ra_ready) && m_rq.size() < MO) g = rr(bus.lsu_ra_valid, m_rlast);
    m_ra_g = '0;
    if (g >= 0) m_ra_g[g] = 1'b1;
    chk("ra_ready", bus.lsu_ra_ready, m_ra_g);
    for (int i = 0; i < N; i++) if (bus.lsu_ra_ready[i]) ra_order.push_back(i);
    chk("ext_ra_valid", bus.ext_ra_valid, m_ra_v);
    if (m_ra_v) chk("ext_ra_addr", bus.ext_ra_addr, m_ra_a);

    e = '0; rrdy = 1'b0;
    if (m_rq.size() > 0) begin
      h = m_rq[0];
      e[h] = bus.ext_rd_valid;
      rrdy = bus.lsu_rd_ready[h];
    end
    chk("lsu_rd_valid", bus.lsu_rd_valid, e);
    chk("ext_rd_ready", bus.ext_rd_ready, rrdy);
    for (int i = 0; i < N; i++) chk("lsu_rd_data", bus.lsu_rd_data[i], bus.ext_rd_data);

    gw = -1;
    if ((!m_wa_v || bus.ext_wa_ready) && (!m_wd_v || bus.ext_wd_ready) && m_wq.size() < MO)
      gw = rr(bus.lsu_wa_valid & bus.lsu_wd_valid, m_wlast);
    m_w_g = '0;
    if (gw >= 0) m_w_g[gw] = 1'b1;
    chk("wa_ready", bus.lsu_wa_ready, m_w_g);
    chk("wd_ready", bus.lsu_wd_ready, m_w_g);
    if (bus.lsu_wa_ready != '0) w_cnt++;
    chk("ext_wa_valid", bus.ext_wa_valid, m_wa_v);
    if (m_wa_v) chk("ext_wa_addr", bus.ext_wa_addr, m_wa_a);
    chk("ext_wd_valid", bus.ext_wd_valid, m_wd_v);
    if (m_wd_v) chk("ext_wd_data_strb", {bus.ext_wd_strb, bus.ext_wd_data}, {m_wd_s, m_wd_d});

    e = '0; wrdy = 1'b0;
    if (m_wq.size() > 0) begin
      h = m_wq[0];
      e[h] = bus.ext_wr_valid;
      wrdy = bus.lsu_wr_ready[h];
    end
    chk("lsu_wr_valid", bus.lsu_wr_valid, e);
    chk("ext_wr_ready", bus.ext_wr_ready, wrdy);

    rpop = (m_rq.size() > 0) && bus.ext_rd_valid && rrdy;
    wpop = (m_wq.size() > 0) && bus.ext_wr_valid && wrdy;
    if (rpop) void'(m_rq.pop_front());
    if (wpop) void'(m_wq.pop_front());
    if (g >= 0) begin
      m_rq.push_back(g); m_ra_v = 1; m_ra_a = bus.lsu_ra_addr[g]; m_rlast = g;
    end else if (bus.ext_ra_ready) m_ra_v = 0;
    if (gw >= 0) begin
      m_wq.push_back(gw); m_wa_v = 1; m_wd_v = 1; m_wlast = gw;
      m_wa_a = bus.lsu_wa_addr[gw]; m_wd_d = bus.lsu_wd_data[gw]; m_wd_s = bus.lsu_wd_strb[gw];
    end else begin
      if (bus.ext_wa_ready) m_wa_v = 0;
      if (bus.ext_wd_ready) m_wd_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // LSU channels drop their request after the handshake.
  task automatic lsu_release();
    bus.lsu_ra_valid = bus.lsu_ra_valid & ~m_ra_g;
    bus.lsu_wa_valid = bus.lsu_wa_valid & ~m_w_g;
    bus.lsu_wd_valid = bus.lsu_wd_valid & ~m_w_g;
  endtask

  initial begin
    bus.lsu_wa_valid = '0; bus.lsu_wa_addr = '0; bus.lsu_wd_valid = '0;
    bus.lsu_wd_data = '0; bus.lsu_wd_strb = '0; bus.lsu_wr_ready = '0;
    bus.lsu_ra_valid = '0; bus.lsu_ra_addr = '0; bus.lsu_rd_ready = '0;
    bus.ext_wa_ready = 0; bus.ext_wd_ready = 0; bus.ext_wr_valid = 0;
    bus.ext_ra_ready = 0; bus.ext_rd_valid = 0; bus.ext_rd_data = '0;
    model_reset();
    w_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    idle_chk("rst");
    arstn = 1'b1;

    // Three simultaneous reads: granted 0,1,2, data routed back in order.
    bus.ext_ra_ready = 1;
    bus.lsu_ra_addr[0] = 32'h0000_1000;
    bus.lsu_ra_addr[1] = 32'h0000_2000;
    bus.lsu_ra_addr[2] = 32'h0000_3000;
    bus.lsu_ra_valid = 3'b111;
    ra_order.delete();
    repeat (4) begin cycle(); lsu_release(); end
    chk("t1_grant_order", order_code(), 64'h123);
    bus.lsu_rd_ready = '1; bus.ext_rd_valid = 1;
    for (int d = 0; d < 3; d++) begin
      bus.ext_rd_data = 32'hD0 + d;
      cycle();
    end

    // ch1 continuous, ch2 joins during ch1's grant: order 1,2,1.
    ra_order.delete();
    bus.lsu_ra_valid = 3'b110;
    for (int i = 0; i < 3; i++) begin
      cycle();
      bus.lsu_ra_valid[2] = bus.lsu_ra_valid[2] & ~m_ra_g[2];
      bus.lsu_ra_addr[1] = bus.lsu_ra_addr[1] + 32'h10;
    end
    chk("t2_grant_order", order_code(), 64'h232);
    bus.lsu_ra_valid = '0;
    repeat (4) cycle();

    // Outstanding limit: 4 grants, stall, one response frees a slot for the next cycle.
    bus.ext_rd_valid = 0;
    ra_order.delete();
    bus.lsu_ra_valid = 3'b001;
    repeat (6) begin cycle(); bus.lsu_ra_addr[0] = bus.lsu_ra_addr[0] + 32'h4; end
    chk("t3_grants_at_limit", ra_order.size(), 4);
    bus.ext_rd_valid = 1; bus.ext_rd_data = 32'hCAFE_0001;
    cycle();
    bus.ext_rd_valid = 0;
    cycle();
    chk("t3_grant_after_free", ra_order.size(), 5);
    bus.lsu_ra_valid = '0; bus.ext_rd_valid = 1;
    repeat (5) cycle();
    bus.ext_rd_valid = 0;

    // Write needs both WA and WD valid; WD stall blocks the next grant.
    w_cnt = 0;
    bus.lsu_wa_addr[0] = 32'hA000_0000; bus.lsu_wd_data[0] = 32'h1234_5678; bus.lsu_wd_strb[0] = 4'hF;
    bus.lsu_wa_valid = 3'b001;
    repeat (5) cycle();
    chk("t4_no_grant_wa_only", w_cnt, 0);
    bus.lsu_wd_valid = 3'b001;
    cycle(); lsu_release();
    bus.lsu_wa_addr[1] = 32'hB000_0000; bus.lsu_wd_data[1] = 32'h9ABC_DEF0; bus.lsu_wd_strb[1] = 4'h3;
    bus.lsu_wa_valid = 3'b010; bus.lsu_wd_valid = 3'b010;
    bus.ext_wa_ready = 1; bus.ext_wd_ready = 0;
    repeat (3) cycle();
    chk("t4_no_grant_wd_stall", w_cnt, 1);
    bus.ext_wd_ready = 1;
    cycle(); lsu_release();
    repeat (2) cycle();
    chk("t4_second_grant", w_cnt, 2);
    bus.ext_wr_valid = 1; bus.lsu_wr_ready = 3'b111;
    repeat (3) cycle();

    // Stray responses with empty ID FIFOs are never acknowledged.
    bus.ext_rd_valid = 1; bus.lsu_rd_ready = '1; bus.ext_rd_data = 32'hDEAD_BEEF;
    repeat (3) cycle();
    bus.ext_rd_valid = 0; bus.ext_wr_valid = 0;

    // Reset with two reads outstanding and the RA slot full.
    bus.ext_ra_ready = 1;
    bus.lsu_ra_addr[0] = 32'h0000_0100; bus.lsu_ra_addr[1] = 32'h0000_0200;
    bus.lsu_ra_valid = 3'b011;
    repeat (2) begin cycle(); lsu_release(); end
    bus.ext_ra_ready = 0;
    bus.lsu_ra_valid = 3'b001;
    bus.ext_rd_data = '0;
    #2;
    arstn = 1'b0;
    #1;
    idle_chk("midrst");
    model_reset();
    @(posedge clk);
    #1;
    arstn = 1'b1;
    bus.lsu_ra_valid = 3'b100; bus.lsu_ra_addr[2] = 32'h0000_0300; bus.ext_ra_ready = 1;
    ra_order.delete();
    repeat (2) begin cycle(); lsu_release(); end
    chk("t6_fresh_grant", order_code(), 64'h3);
    bus.ext_rd_valid = 1; bus.ext_rd_data = 32'h5555_0300;
    cycle();
    bus.ext_rd_valid = 0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.lsu_ra_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.lsu_ra_valid[i] = 1; bus.lsu_ra_addr[i] = $urandom;
        end
        if (!bus.lsu_wa_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.lsu_wa_valid[i] = 1; bus.lsu_wa_addr[i] = $urandom;
        end
        if (!bus.lsu_wd_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.lsu_wd_valid[i] = 1; bus.lsu_wd_data[i] = $urandom;
          bus.lsu_wd_strb[i] = SW'($urandom);
        end
      end
      bus.ext_ra_ready = 1'($urandom); bus.ext_wa_ready = 1'($urandom);
      bus.ext_wd_ready = 1'($urandom);
      bus.ext_rd_valid = 1'($urandom); bus.ext_rd_data = $urandom;
      bus.ext_wr_valid = 1'($urandom);
      bus.lsu_rd_ready = N'($urandom); bus.lsu_wr_ready = N'($urandom);
      cycle();
      lsu_release();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
